spi_frame_arbiter: RTL and testbench



---
 rtl/spi_arb_pkg.sv | 16 +
 rtl/spi_shift_engine.sv | 87 ++++++++
 rtl/spi_frame_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_spi_frame_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI frame arbiter: FSM state codes, requester indices, byte width.
package spi_arb_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned NUM_REQ       = 2;
  localparam int unsigned REQ_CPU       = 0;
  localparam int unsigned REQ_REFRESH   = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  typedef logic [BITS_PER_BYTE-1:0] byte_t;

endpackage

// File: rtl/spi_shift_engine.sv
// Serialises one byte MSB first on sck/mosi; done_c_o flags the cycle of the last falling sck edge.
module spi_shift_engine
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          MOSI_INV = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start_i,
  input  byte_t data_i,
  output logic  sck_o,
  output logic  mosi_o,
  output logic  done_c_o
);

  localparam int unsigned DIV_W = 4;
  localparam int unsigned IDX_W = $clog2(BITS_PER_BYTE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(BITS_PER_BYTE - 1);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  byte_t            data_q, data_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             terminal_c;

  assign terminal_c = (div_q == DIV_LAST);
  assign done_c_o   = active_q & terminal_c & sck_q & (idx_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= MOSI_INV;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end

  // Falling sck edges advance the bit; mosi holds after the last bit until the next start.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    idx_d    = idx_q;
    data_d   = data_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    if (start_i) begin
      active_d = 1'b1;
      div_d    = '0;
      idx_d    = IDX_MSB;
      data_d   = data_i;
      sck_d    = 1'b0;
      mosi_d   = data_i[BITS_PER_BYTE-1] ^ MOSI_INV;
    end else if (active_q) begin
      if (terminal_c) begin
        div_d = '0;
        sck_d = ~sck_q;
        if (sck_q) begin
          if (idx_q == '0) begin
            active_d = 1'b0;
          end else begin
            idx_d  = IDX_W'(idx_q - IDX_W'(1));
            mosi_d = data_q[IDX_W'(idx_q - IDX_W'(1))] ^ MOSI_INV;
          end
        end
      end else begin
        div_d = DIV_W'(div_q + DIV_W'(1));
      end
    end
  end

  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_frame_arbiter.sv
// Round-robin per-frame arbiter and frame FSM for the shared SPI output channel.
// Optional mid-frame starvation abort is built when SPI_TIMEOUT_EN is defined.
module spi_frame_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned LOAD_LEN = 2,
  parameter bit          MOSI_INV = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  input  logic [7:0]         req_data0_i,
  input  logic [7:0]         req_data1_i,
  input  logic [NUM_REQ-1:0] req_last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               sck_o,
  output logic               mosi_o,
  output logic               load_o,
  output logic               abort_o
);

  localparam int unsigned LCNT_W = 3;
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOAD_LEN - 1);
  // An out-of-range configuration never grants the channel.
  localparam bit CFG_OK = (CLK_DIV >= 1) && (CLK_DIV <= 15) && (LOAD_LEN >= 1) &&
                          (LOAD_LEN <= 7) && (TIMEOUT >= 1);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               rr_q, rr_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;

  logic               cand_c, any_c, sel_c, hs_c, shift_done_c;
  logic [NUM_REQ-1:0] ready_c;
  byte_t              byte_c;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              abort_q, abort_d;
`endif

  // Candidate selection and handshake; the non-owner is never served mid-frame.
  always_comb begin
    any_c   = (|req_valid_i) && CFG_OK;
    cand_c  = (&req_valid_i) ? rr_q : req_valid_i[REQ_REFRESH];
    ready_c = '0;
    if (rst_n) begin
      if ((state_q == ST_IDLE) && any_c) begin
        ready_c[cand_c] = 1'b1;
      end else if (state_q == ST_WAIT) begin
        ready_c[owner_q] = 1'b1;
      end
    end
    sel_c  = (state_q == ST_WAIT) ? owner_q : cand_c;
    hs_c   = |(req_valid_i & ready_c);
    byte_c = (sel_c == 1'(REQ_REFRESH)) ? req_data1_i : req_data0_i;
  end

  spi_shift_engine #(
    .CLK_DIV  (CLK_DIV),
    .MOSI_INV (MOSI_INV)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (hs_c),
    .data_i   (byte_c),
    .sck_o    (sck_o),
    .mosi_o   (mosi_o),
    .done_c_o (shift_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      rr_q    <= 1'b0;
      lcnt_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
`ifdef SPI_TIMEOUT_EN
      wcnt_q  <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
      lcnt_q  <= lcnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
`ifdef SPI_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      abort_q <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rr_d    = rr_q;
    lcnt_d  = lcnt_q;
    grant_d = grant_q;
`ifdef SPI_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    abort_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          state_d         = ST_SHIFT;
          owner_d         = cand_c;
          last_d          = req_last_i[cand_c];
          grant_d         = '0;
          grant_d[cand_c] = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift_done_c) begin
          if (last_q) begin
            state_d = ST_LOAD;
            lcnt_d  = '0;
          end else begin
            state_d = ST_WAIT;
`ifdef SPI_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (hs_c) begin
          state_d = ST_SHIFT;
          last_d  = req_last_i[owner_q];
        end
`ifdef SPI_TIMEOUT_EN
        else if (wcnt_q == WCNT_LAST) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = ~owner_q;
          abort_d = 1'b1;
        end else begin
          wcnt_d = WCNT_W'(wcnt_q + WCNT_W'(1));
        end
`endif
      end
      ST_LOAD: begin
        if (lcnt_q == LCNT_LAST) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = ~owner_q;
        end else begin
          lcnt_d = LCNT_W'(lcnt_q + LCNT_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    load_d = (state_d == ST_LOAD);
  end

  assign req_ready_o = ready_c;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign load_o      = load_q;
`ifdef SPI_TIMEOUT_EN
  assign abort_o     = abort_q;
`else
  assign abort_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: frame-level reference model checked every cycle plus directed literal checks.
// Also exercises the abort path when SPI_TIMEOUT_EN is defined.
module tb_spi_frame_arbiter;

  localparam int unsigned CD  = 2;
  localparam int unsigned LL  = 2;
  localparam int unsigned TO  = 10;
  localparam bit          INV = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready, req_last = 2'b00, grant;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       busy, sck, mosi, load, abort;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_frame_arbiter #(.CLK_DIV(CD), .LOAD_LEN(LL), .MOSI_INV(INV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data0_i(d0), .req_data1_i(d1), .req_last_i(req_last), .grant_o(grant),
    .busy_o(busy), .sck_o(sck), .mosi_o(mosi), .load_o(load), .abort_o(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: 0 idle, 1 shifting (m_t = cycle within byte), 2 waiting, 3 load.
  int         m_st = 0, m_t = 0;
  bit         m_owner = 0, m_last = 0, m_rr = 0, m_hold = INV, m_abort = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic bit m_cand();
    return (&req_valid) ? m_rr : req_valid[1];
  endfunction

  function automatic bit mosi_at(input int t);
    return m_byte[7 - t / (2 * CD)] ^ INV;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_t = 0; m_owner = 0; m_last = 0; m_rr = 0; m_hold = INV; m_abort = 0;
    end else begin
      m_abort = 0;
      case (m_st)
        0: if (|req_valid) begin
             m_owner = m_cand();
             m_byte  = m_owner ? d1 : d0;
             m_last  = req_last[m_owner];
             m_st = 1; m_t = 0;
           end
        1: begin
             m_hold = mosi_at(m_t);
             if (m_t == 16 * CD - 1) begin
               m_st = m_last ? 3 : 2; m_t = 0;
             end else m_t++;
           end
        2: if (req_valid[m_owner]) begin
             m_byte = m_owner ? d1 : d0;
             m_last = req_last[m_owner];
             m_st = 1; m_t = 0;
           end
`ifdef SPI_TIMEOUT_EN
           else if (m_t == TO - 1) begin
             m_st = 0; m_rr = ~m_owner; m_abort = 1;
           end else m_t++;
`endif
        default: if (m_t == LL - 1) begin
             m_st = 0; m_rr = ~m_owner;
           end else m_t++;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [1:0] er;
    er = 2'b00;
    if (rst_n) begin
      if (m_st == 0 && |req_valid) er[m_cand()] = 1'b1;
      else if (m_st == 2) er[m_owner] = 1'b1;
    end
    chk("ready", 16'(req_ready), 16'(er));
    chk("grant", 16'(grant), (m_st != 0) ? (m_owner ? 16'd2 : 16'd1) : 16'd0);
    chk("busy", 16'(busy), 16'(m_st != 0));
    chk("load", 16'(load), 16'(m_st == 3));
    chk("sck", 16'(sck), (m_st == 1) ? 16'((m_t / CD) % 2) : 16'd0);
    chk("mosi", 16'(mosi), (m_st == 1) ? 16'(mosi_at(m_t)) : 16'(m_hold));
`ifdef SPI_TIMEOUT_EN
    chk("abort", 16'(abort), 16'(m_abort));
`else
    chk("abort", 16'(abort), 16'd0);
`endif
  end

  // Event recorder used by the directed literal checks.
  int          rises, loads, load_hi, load_start, gcount, abort_cyc;
  logic [15:0] cap;
  logic [1:0]  g [8];
  bit          r1_seen, sck_p, load_p, busy_p;

  always @(negedge clk) begin
    if (sck && !sck_p) begin rises++; cap = {cap[14:0], mosi}; end
    if (load && !load_p) begin loads++; load_start = cyc; end
    if (load) load_hi++;
    if (busy && !busy_p && gcount < 8) begin g[gcount] = grant; gcount++; end
    if (abort) abort_cyc = cyc;
    if (grant == 2'b01 && req_ready[1]) r1_seen = 1;
    sck_p = sck; load_p = load; busy_p = busy;
  end

  task automatic clear();
    rises = 0; loads = 0; load_hi = 0; load_start = -1; gcount = 0;
    abort_cyc = -1; cap = '0; r1_seen = 0;
  endtask

  // Offer a byte and wait for its handshake; h is the clock edge number of the handshake.
  task automatic send(input int r, input logic [7:0] d, input logic l, input bit keep,
                      output int h);
    int n;
    if (r == 0) d0 = d; else d1 = d;
    req_last[r]  = l;
    req_valid[r] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[r] && n < 2000) begin @(negedge clk); n++; end
    chk($sformatf("ready_wait%0d", r), 16'(req_ready[r]), 16'd1);
    h = cyc + 1;
    @(posedge clk); #2;
    if (!keep) req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 1000);
    chk("idle_reached", 16'(busy), 16'd0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int h, h1, h2, h3;
    clear();
    req_valid = 2'b11; d0 = 8'h11; d1 = 8'h22; req_last = 2'b11;
    #23;
    chk("rst_sck", 16'(sck), 16'd0);
    chk("rst_mosi", 16'(mosi), 16'd1);
    chk("rst_grant", 16'(grant), 16'd0);
    chk("rst_load", 16'(load), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd0);
    rst_n = 1'b1;

    // Round robin with both requesters always valid.
    begin : rr_test
      int n;
      n = 0;
      while (gcount < 4 && n < 400) begin @(negedge clk); n++; end
      @(posedge clk); #2;
      req_valid = 2'b00;
      wait_idle();
      chk("rr_g0", 16'(g[0]), 16'h1);
      chk("rr_g1", 16'(g[1]), 16'h2);
      chk("rr_g2", 16'(g[2]), 16'h1);
      chk("rr_g3", 16'(g[3]), 16'h2);
    end

    // Single-byte frame.
    clear();
    send(0, 8'hA5, 1'b1, 1'b0, h);
    wait_idle();
    chk("single_rises", 16'(rises), 16'd8);
    chk("single_bits", 16'(cap[7:0]), 16'h5A);
    chk("single_load_start", 16'(load_start - h), 16'd32);
    chk("single_load_width", 16'(load_hi), 16'd2);
    chk("single_grant", 16'(g[0]), 16'h1);

    // Three-byte frame with the other requester knocking throughout.
    clear();
    send(0, 8'h01, 1'b0, 1'b1, h1);
    d1 = 8'hFF; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    send(0, 8'h02, 1'b0, 1'b1, h2);
    send(0, 8'h03, 1'b1, 1'b0, h3);
    wait_idle();
    chk("multi_gap12", 16'(h2 - h1), 16'd33);
    chk("multi_gap23", 16'(h3 - h2), 16'd33);
    chk("multi_loads", 16'(loads), 16'd1);
    chk("multi_rises", 16'(rises), 16'd24);
    chk("multi_bits", cap, 16'hFDFC);
    chk("multi_r1_blocked", 16'(r1_seen), 16'd0);
    send(1, 8'hFF, 1'b1, 1'b0, h);
    wait_idle();

    // Owner stalls between bytes.
    clear();
    send(1, 8'hC3, 1'b0, 1'b0, h);
`ifndef SPI_TIMEOUT_EN
    d0 = 8'h00; req_last[0] = 1'b1; req_valid[0] = 1'b1;
`endif
    wait_cyc(h + 52);
`ifdef SPI_TIMEOUT_EN
    chk("to_abort_cyc", 16'(abort_cyc - h), 16'd42);
    chk("to_no_load", 16'(loads), 16'd0);
    chk("to_idle", 16'(busy), 16'd0);
    send(0, 8'h00, 1'b1, 1'b0, h2);
    wait_idle();
    chk("to_next_grant", 16'(g[1]), 16'h1);
`else
    chk("stall_busy", 16'(busy), 16'd1);
    chk("stall_grant", 16'(grant), 16'h2);
    chk("stall_sck", 16'(sck), 16'd0);
    chk("stall_no_load", 16'(loads), 16'd0);
    chk("stall_r0_blocked", 16'(req_ready[0]), 16'd0);
    send(1, 8'h3C, 1'b1, 1'b0, h2);
    wait_idle();
    chk("stall_bits", cap, 16'h3CC3);
    chk("stall_loads", 16'(loads), 16'd1);
    send(0, 8'h00, 1'b1, 1'b0, h2);
    wait_idle();
`endif

    // Reset during bit 4 of a byte.
    clear();
    send(0, 8'hF0, 1'b1, 1'b0, h);
    wait_cyc(h + 13);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sck", 16'(sck), 16'd0);
    chk("mid_rst_load", 16'(load), 16'd0);
    chk("mid_rst_grant", 16'(grant), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_mosi", 16'(mosi), 16'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear();
    send(0, 8'h81, 1'b1, 1'b0, h);
    wait_idle();
    chk("post_rst_rises", 16'(rises), 16'd8);
    chk("post_rst_bits", 16'(cap[7:0]), 16'h7E);
    chk("post_rst_loads", 16'(loads), 16'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
